// File: rtl/blur_filter_pipe.sv
// Streaming 3x3 image filter (pass / gaussian / box average / sharpen) built
// on two line buffers, with a fixed 2-cycle latency and frame-aligned mode switching.
module blur_filter_pipe #(
    parameter int CH_W   = 4,
    parameter int CHAN   = 3,
    parameter int LINE_W = 640
) (
    input  logic                 writeClk,
    input  logic                 resetN,
    input  logic [CH_W*CHAN-1:0] pixelIn,
    input  logic                 pixelValid,
    input  logic                 lineStart,
    input  logic                 frameStart,
    input  logic                 modeStep,
    output logic [CH_W*CHAN-1:0] pixelOut,
    output logic                 pixelOutValid,
    output logic [1:0]           activeMode
);
    localparam int PIX_W = CH_W * CHAN;
    localparam int X_W   = $clog2(LINE_W);
    // The spare bit lets x run past LINE_W-1, so overlong lines are dropped instead of wrapping.
    localparam int XC_W  = X_W + 1;
    localparam int Y_W   = XC_W;
    localparam int SW    = CH_W + 4;
    localparam logic [XC_W-1:0] X_LIMIT = XC_W'(LINE_W);
    localparam logic [CH_W-1:0] CH_MAX  = '1;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_GAUSS = 2'd1,
        MODE_AVG   = 2'd2,
        MODE_SHARP = 2'd3
    } mode_e;

    logic [XC_W-1:0]  x_q, x_cur;
    logic [Y_W-1:0]   y_q, y_cur;
    logic [X_W-1:0]   x_idx;
    logic             frame_q, accept, in_range, wr_en;
    logic [1:0]       sync_q;
    logic             step_prev_q, step_rise;
    mode_e            pending_q, active_q, mode1_q;
    logic             v1_q, pass1_q, valid_q;
    logic [PIX_W-1:0] pix_out_q, out_d, tap1, tap2;
    logic [PIX_W-1:0] lb0 [LINE_W];
    logic [PIX_W-1:0] lb1 [LINE_W];
    logic [PIX_W-1:0] win_q [3][3];

    // Pixels arriving after reset are ignored until the first frameStart.
    assign accept    = pixelValid && (frame_q || frameStart);
    assign x_cur     = (lineStart || frameStart) ? '0 : ((&x_q) ? x_q : x_q + XC_W'(1));
    assign y_cur     = frameStart ? '0 : ((lineStart && !(&y_q)) ? y_q + Y_W'(1) : y_q);
    assign in_range  = x_cur < X_LIMIT;
    assign wr_en     = accept && in_range;
    assign x_idx     = x_cur[X_W-1:0];
    assign tap1      = lb0[x_idx];
    assign tap2      = lb1[x_idx];
    assign step_rise = sync_q[1] && !step_prev_q;

    // NOTE: every sequential block uses non-blocking assignments so all flops
    // sample pre-edge values; blocking here would silently collapse pipeline stages.
    always_ff @(posedge writeClk or negedge resetN) begin
        if (!resetN) begin
            x_q         <= '0;
            y_q         <= '0;
            frame_q     <= 1'b0;
            sync_q      <= '0;
            step_prev_q <= 1'b0;
            pending_q   <= MODE_PASS;
            active_q    <= MODE_PASS;
            mode1_q     <= MODE_PASS;
            pass1_q     <= 1'b0;
            v1_q        <= 1'b0;
            valid_q     <= 1'b0;
            pix_out_q   <= '0;
        end else begin
            sync_q      <= {sync_q[0], modeStep};
            step_prev_q <= sync_q[1];
            if (step_rise)
                pending_q <= mode_e'(pending_q + 2'd1);
            if (accept) begin
                x_q <= x_cur;
                y_q <= y_cur;
                if (frameStart) begin
                    frame_q  <= 1'b1;
                    active_q <= pending_q;
                end
            end
            v1_q <= wr_en;
            if (wr_en) begin
                mode1_q <= frameStart ? pending_q : active_q;
                pass1_q <= (x_cur < XC_W'(2)) || (y_cur < Y_W'(2));
            end
            valid_q <= v1_q;
            if (v1_q)
                pix_out_q <= out_d;
        end
    end

    // NOTE: line buffers and window are pure datapath storage with no reset;
    // the x<2 / y<2 pass-through masks their stale contents.
    always_ff @(posedge writeClk) begin
        if (wr_en) begin
            lb0[x_idx] <= pixelIn;
            lb1[x_idx] <= tap1;
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= tap2;
            win_q[1][2] <= tap1;
            win_q[2][2] <= pixelIn;
        end
    end

    // t[0..8] is the window in raster order; t[4] is the centre.
    function automatic logic [CH_W-1:0] filter_ch(input mode_e mode, input logic [CH_W-1:0] t [9]);
        logic [SW-1:0]   corners, edges, sum9, gsum, sharp;
        logic [SW+5:0]   avg;
        logic [CH_W-1:0] res;
        corners = SW'(t[0]) + SW'(t[2]) + SW'(t[6]) + SW'(t[8]);
        edges   = SW'(t[1]) + SW'(t[3]) + SW'(t[5]) + SW'(t[7]);
        sum9    = corners + edges + SW'(t[4]);
        gsum    = corners + (edges << 1) + (SW'(t[4]) << 2);
        avg     = ((SW+6)'(sum9) * (SW+6)'(57)) >> 9;
        sharp   = SW'(5) * SW'(t[4]) - edges;
        case (mode)
            MODE_GAUSS: res = CH_W'(gsum >> 4);
            MODE_AVG:   res = (avg > (SW+6)'(CH_MAX)) ? CH_MAX : CH_W'(avg);
            MODE_SHARP: begin
                if (sharp[SW-1])
                    res = '0;
                else if (sharp > SW'(CH_MAX))
                    res = CH_MAX;
                else
                    res = CH_W'(sharp);
            end
            default:    res = t[4];
        endcase
        return res;
    endfunction

    for (genvar c = 0; c < CHAN; c++) begin : g_ch
        logic [CH_W-1:0] taps [9];
        for (genvar k = 0; k < 9; k++) begin : g_tap
            assign taps[k] = win_q[k/3][k%3][c*CH_W +: CH_W];
        end
        assign out_d[c*CH_W +: CH_W] = pass1_q ? taps[4] : filter_ch(mode1_q, taps);
    end

    assign pixelOut      = pix_out_q;
    assign pixelOutValid = valid_q;
    assign activeMode    = active_q;
endmodule

// File: tb/tb_blur_filter_pipe.sv
// Randomized bench for blur_filter_pipe: a 2D-image reference model predicts
// every filtered pixel and its output cycle; scenario tasks compare against it.
module tb_blur_filter_pipe;
    localparam int LW = 16;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [11:0] pixelIn = '0;
    logic        pixelValid = 1'b0, lineStart = 1'b0, frameStart = 1'b0, modeStep = 1'b0;
    logic [11:0] pixelOut;
    logic        pixelOutValid;
    logic [1:0]  activeMode;

    blur_filter_pipe #(.CH_W(4), .CHAN(3), .LINE_W(LW)) dut (
        .writeClk(clk), .resetN(resetN), .pixelIn(pixelIn), .pixelValid(pixelValid),
        .lineStart(lineStart), .frameStart(frameStart), .modeStep(modeStep),
        .pixelOut(pixelOut), .pixelOutValid(pixelOutValid), .activeMode(activeMode)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [11:0] val; int cyc; } obs_t;
    typedef struct { logic [11:0] val; bit chk; int cyc; } exp_t;
    obs_t obs_q[$];
    exp_t exp_q[$];

    int tests = 0, fails = 0;

    // Reference model state: image of the current frame plus mode bookkeeping.
    logic [11:0] img [16][LW];
    int mx, my, m_pend = 0, m_active = 0;
    bit m_frame = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (pixelOutValid === 1'b1) obs_q.push_back('{val: pixelOut, cyc: cyc});
    end

    function automatic logic [11:0] ref_pix(int mode, int x, int y);
        logic [11:0] r;
        int p[3][3];
        int v, e;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            for (int dy = 0; dy < 3; dy++)
                for (int dx = 0; dx < 3; dx++)
                    p[dy][dx] = int'((img[y-2+dy][x-2+dx] >> (4*c)) & 12'hF);
            e = p[0][1] + p[1][0] + p[1][2] + p[2][1];
            case (mode)
                1: v = (p[0][0] + p[0][2] + p[2][0] + p[2][2] + 2*e + 4*p[1][1]) / 16;
                2: begin
                    v = (p[0][0] + p[0][2] + p[2][0] + p[2][2] + e + p[1][1]) * 57 / 512;
                    if (v > 15) v = 15;
                end
                3: begin
                    v = 5*p[1][1] - e;
                    if (v < 0) v = 0;
                    if (v > 15) v = 15;
                end
                default: v = p[1][1];
            endcase
            r[4*c +: 4] = 4'(v);
        end
        return r;
    endfunction

    function automatic logic [11:0] gen_pix(int kind, int x, int y);
        logic [3:0] xs, ys;
        xs = 4'(x);
        ys = 4'(y);
        case (kind)
            1: return {ys, xs, ys};
            2: return (x == 3 && y == 2) ? 12'hFFF : 12'h000;
            3: return 12'h999;
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic model_accept(input logic [11:0] pix, input bit ls, input bit fs);
        exp_t e;
        if (!(m_frame || fs)) return;
        if (fs) begin
            m_frame = 1; m_active = m_pend; mx = 0; my = 0;
        end else if (ls) begin
            mx = 0; my++;
        end else begin
            mx++;
        end
        if (mx >= LW) return;
        img[my][mx] = pix;
        e.cyc = cyc + 2;
        e.val = '0;
        e.chk = 1;
        if (mx < 2 || my < 2) begin
            e.chk = (mx >= 1 && my >= 1);
            if (e.chk) e.val = img[my-1][mx-1];
        end else begin
            e.val = ref_pix(m_active, mx, my);
        end
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [11:0] pix, input bit ls, input bit fs);
        @(negedge clk);
        pixelIn = pix; lineStart = ls; frameStart = fs; pixelValid = 1'b1;
        model_accept(pix, ls, fs);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pixelValid = 1'b0; lineStart = 1'b0; frameStart = 1'b0;
        end
    endtask

    task automatic send_frame(input int w, input int h, input int kind, input bit gap);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                send(gen_pix(kind, x, y), x == 0, x == 0 && y == 0);
                if (gap) idle(1);
            end
        idle(4);
    endtask

    task automatic pulse_mode;
        idle(1);
        modeStep = 1'b1;
        idle(4);
        modeStep = 1'b0;
        idle(4);
        m_pend = (m_pend + 1) % 4;
    endtask

    task automatic set_mode(input int m);
        for (int i = 0; i < 4 && m_pend != m; i++) pulse_mode();
    endtask

    task automatic test_reset;
        tests++;
        if (pixelOut !== 12'h000) begin
            fails++; $display("FAIL reset_pixelOut: got %h, expected 000", pixelOut);
        end
        tests++;
        if (pixelOutValid !== 1'b0) begin
            fails++; $display("FAIL reset_valid: got %b, expected 0", pixelOutValid);
        end
        tests++;
        if (activeMode !== 2'd0) begin
            fails++; $display("FAIL reset_mode: got %0d, expected 0", activeMode);
        end
    endtask

    task automatic test_pass;
        set_mode(0);
        send_frame(4, 4, 1, 0);
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL pass_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i].cyc !== exp_q[i].cyc || (exp_q[i].chk && obs_q[i].val !== exp_q[i].val)) begin
                fails++;
                $display("FAIL pass[%0d]: got %h at cycle %0d, expected %h at cycle %0d",
                         i, obs_q[i].val, obs_q[i].cyc, exp_q[i].val, exp_q[i].cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_filters;
        set_mode(1);
        send_frame(8, 5, 0, 0);
        send_frame(8, 4, 2, 0);
        set_mode(2);
        send_frame(8, 5, 0, 0);
        send_frame(6, 4, 3, 0);
        set_mode(3);
        send_frame(8, 5, 0, 0);
        send_frame(6, 4, 3, 0);
        send_frame(8, 4, 2, 0);
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL filter_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i].cyc !== exp_q[i].cyc || (exp_q[i].chk && obs_q[i].val !== exp_q[i].val)) begin
                fails++;
                $display("FAIL filter[%0d]: got %h at cycle %0d, expected %h at cycle %0d",
                         i, obs_q[i].val, obs_q[i].cyc, exp_q[i].val, exp_q[i].cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_mode_timing;
        int old;
        // Mode step in the middle of a frame must wait for the next frameStart.
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) begin
                send(gen_pix(0, x, y), x == 0, x == 0 && y == 0);
                if (y == 1 && x == 1) begin
                    modeStep = 1'b1;
                    m_pend = (m_pend + 1) % 4;
                end
                if (y == 3 && x == 0) modeStep = 1'b0;
            end
        idle(4);
        tests++;
        if (activeMode !== 2'(m_active)) begin
            fails++; $display("FAIL mode_hold: got %0d, expected %0d", activeMode, m_active);
        end
        send_frame(4, 4, 0, 0);
        tests++;
        if (activeMode !== 2'(m_pend)) begin
            fails++; $display("FAIL mode_load: got %0d, expected %0d", activeMode, m_pend);
        end
        // Detected edge lands on the same clock as the frameStart pixel.
        old = m_pend;
        @(negedge clk);
        modeStep = 1'b1;
        @(negedge clk);
        send_frame(4, 4, 0, 0);
        m_pend = (m_pend + 1) % 4;
        modeStep = 1'b0;
        tests++;
        if (activeMode !== 2'(old)) begin
            fails++; $display("FAIL mode_coincide: got %0d, expected %0d", activeMode, old);
        end
        idle(4);
        send_frame(4, 4, 0, 0);
        tests++;
        if (activeMode !== 2'(m_pend)) begin
            fails++; $display("FAIL mode_next: got %0d, expected %0d", activeMode, m_pend);
        end
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL mode_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i].cyc !== exp_q[i].cyc || (exp_q[i].chk && obs_q[i].val !== exp_q[i].val)) begin
                fails++;
                $display("FAIL mode[%0d]: got %h at cycle %0d, expected %h at cycle %0d",
                         i, obs_q[i].val, obs_q[i].cyc, exp_q[i].val, exp_q[i].cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_bubbles;
        set_mode(1);
        send_frame(8, 5, 0, 1);
        send_frame(LW + 3, 3, 0, 0);
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL bubble_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i].cyc !== exp_q[i].cyc || (exp_q[i].chk && obs_q[i].val !== exp_q[i].val)) begin
                fails++;
                $display("FAIL bubble[%0d]: got %h at cycle %0d, expected %h at cycle %0d",
                         i, obs_q[i].val, obs_q[i].cyc, exp_q[i].val, exp_q[i].cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_midline;
        set_mode(3);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8 && !(y == 3 && x > 5); x++)
                send(gen_pix(0, x, y), x == 0, x == 0 && y == 0);
        @(negedge clk);
        resetN = 1'b0;
        pixelValid = 1'b0;
        #1;
        test_reset();
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        m_frame = 0; m_pend = 0; m_active = 0;
        idle(2);
        resetN = 1'b1;
        // Rest of the interrupted line and a further line, with no frameStart.
        send(gen_pix(0, 6, 3), 0, 0);
        send(gen_pix(0, 7, 3), 0, 0);
        for (int x = 0; x < 8; x++) send(gen_pix(0, x, 4), x == 0, 0);
        idle(4);
        send_frame(4, 4, 0, 0);
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL rst_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i].cyc !== exp_q[i].cyc || (exp_q[i].chk && obs_q[i].val !== exp_q[i].val)) begin
                fails++;
                $display("FAIL rst[%0d]: got %h at cycle %0d, expected %h at cycle %0d",
                         i, obs_q[i].val, obs_q[i].cyc, exp_q[i].val, exp_q[i].cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        idle(3);
        test_reset();
        resetN = 1'b1;
        idle(2);
        test_reset();
        test_pass();
        test_filters();
        test_mode_timing();
        test_bubbles();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
